rtc_calendar_core: RTL and testbench
====================================

// Module: rtc_calendar_core
// PURPOSE
//  Second-generation real-time clock/calendar core. Derives a 1 Hz tick internally from a fast system clock via
//  a parametrised prescaler. Time is stored in 24 h form and presented in 12 h or 24 h form without disturbing the
//  count. Adds validated preset loading, full Gregorian leap rule, a year-range wrap and an HH:MM:SS alarm.
//  Sits between the bus register file (load/alarm config) and the display/interrupt logic.
// PARAMETERS
//  CLK_HZ    32768  system clock cycles per second (>=2); prescaler divisor
//  YEAR_W    12     width of year field
//  YEAR_MIN  2000   lowest valid year; reset year
//  YEAR_MAX  2099   highest valid year; wraps to YEAR_MIN after Dec 31 23:59:59
// PORTS
//  clk_i          in   1       system clock
//  rst_i          in   1       asynchronous active-high reset
//  run_i          in   1       1: prescaler/calendar advance; 0: frozen (prescaler holds its count)
//  mode12_i       in   1       1: 12 h presentation, 0: 24 h
//  load_i         in   1       one-cycle pulse: request preset from load_* fields
//  load_sec_i     in   6       preset seconds 0-59
//  load_min_i     in   6       preset minutes 0-59
//  load_hour_i    in   5       preset hour, always 24 h form 0-23
//  load_dow_i     in   3       preset day of week 1-7
//  load_dom_i     in   5       preset day of month 1-max
//  load_month_i   in   4       preset month 1-12
//  load_year_i    in   YEAR_W  preset year YEAR_MIN..YEAR_MAX
//  alarm_en_i     in   1       alarm compare enable
//  alarm_sec_i    in   6       alarm seconds
//  alarm_min_i    in   6       alarm minutes
//  alarm_hour_i   in   5       alarm hour, 24 h form
//  alarm_clr_i    in   1       clears alarm_pend_o
//  sec_o          out  6       seconds
//  min_o          out  6       minutes
//  hour_o         out  5       0-23 (24 h) or 1-12 (12 h)
//  pm_o           out  1       PM flag in 12 h mode, 0 in 24 h mode
//  dow_o          out  3       day of week 1-7
//  dom_o          out  5       day of month
//  month_o        out  4       month
//  year_o         out  YEAR_W  year
//  sec_tick_o     out  1       one-cycle pulse per second advance
//  load_ok_o      out  1       one-cycle pulse: preset accepted
//  load_err_o     out  1       one-cycle pulse: preset rejected
//  year_wrap_o    out  1       one-cycle pulse on YEAR_MAX->YEAR_MIN wrap
//  alarm_o        out  1       one-cycle pulse on alarm match
//  alarm_pend_o   out  1       sticky alarm flag
// BEHAVIOUR
//  - Reset: 00:00:00, dow 1, 1 Jan YEAR_MIN, prescaler 0, all pulses and alarm_pend_o 0.
//  - Prescaler counts 0..CLK_HZ-1 while run_i=1. Tick when the count = CLK_HZ-1 (count returns to 0).
//    The tick registers the next time at the same edge, with sec_tick_o high the following cycle.
//  - Tick carry chain: sec 59->0 carries min; min 59->0 carries hour; hour 23->0 carries the day.
//    Day carry: dow 7->1, else +1. dom==days_in_month -> dom 1 with month carry; month 12->1 carries year.
//    Year YEAR_MAX->YEAR_MIN with year_wrap_o.
//  - Leap year: (y%4==0 && y%100!=0) || y%400==0. Feb=29/28. Apr/Jun/Sep/Nov=30. Others=31.
//  - Load: all fields are validated against the ranges above. dom is checked against the days of the loaded
//    month and year.
//    Valid: registers take the fields next edge, prescaler cleared to 0, load_ok_o pulses.
//    Invalid: no state change, load_err_o pulses.
//    Load outranks a coincident tick (the tick is dropped) and is accepted regardless of run_i.
//  - Presentation: combinational from stored 24 h hour h.
//    mode12_i=1: hour_o = (h%12==0) ? 12 : h%12, pm_o = (h>=12).
//    mode12_i=0: hour_o = h, pm_o = 0.
//    Toggling mode12_i never alters stored state.
//  - Alarm: evaluated only on tick-driven updates, never on load.
//    If alarm_en_i and the next h:m:s equals alarm_*, then alarm_o is high in the first cycle the outputs show
//    the alarm time, and alarm_pend_o sets.
//    alarm_pend_o is cleared by alarm_clr_i. A coincident set wins over the clear.
//  - run_i=0: no ticks, no alarm. Prescaler resumes from its held count.
//  - rst_i mid-count returns everything to reset values asynchronously.
// STRUCTURE
//  - rtc_pkg holds:
//    - typedef rtc_time_t: struct of sec/min/hour/dow/dom/month/year;
//    - functions is_leap(year) and days_in_month(month, year);
//    - constants for field widths.
//  - Sub-module rtc_prescaler (CLK_HZ, run_i, clear_i -> tick_o), instantiated once.
//  - Carry chain, load validation and alarm compare are in the top-level module.
// TESTING (bench with CLK_HZ=4)
//  1) Reset, then run_i=1 for 4 cycles -> sec_o=1, one sec_tick_o pulse. Set run_i=0 -> values frozen.
//  2) Load 2024-02-28 23:59:59 dow 7, then one tick -> 2024-02-29 00:00:00, dow 1.
//     Load 2100-02-28 23:59:59 (YEAR_MAX=2100), then tick -> 2100-03-01.
//  3) Load 2099-12-31 23:59:59, then tick -> 2000-01-01 00:00:00, with year_wrap_o pulse.
//  4) Load month 4, dom 31 -> load_err_o pulse, outputs unchanged.
//     Load coincident with a tick -> loaded values exactly, with load_ok_o.
//  5) h=0 with mode12_i=1 -> hour_o=12, pm_o=0. h=13 -> hour_o=1, pm_o=1.
//     Toggle mode12_i mid-second -> sec_o and the prescaler are unaffected.
//  6) Alarm 07:30:00 enabled, load 07:29:59, then tick -> alarm_o for one cycle, alarm_pend_o held until alarm_clr_i.
//     Loading 07:30:00 directly -> no alarm. Assert rst_i mid-count -> reset values at once.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared calendar types, field widths and Gregorian month-length helpers for the RTC core.
// Year is held 16 bits wide internally so one struct serves any YEAR_W up to 16.
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DOW_W   = 3;
  localparam int DOM_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_FW = 16;

  typedef struct packed {
    logic [YEAR_FW-1:0] year;
    logic [MONTH_W-1:0] month;
    logic [DOM_W-1:0]   dom;
    logic [DOW_W-1:0]   dow;
    logic [HOUR_W-1:0]  hour;
    logic [MIN_W-1:0]   min;
    logic [SEC_W-1:0]   sec;
  } rtc_time_t;

  function automatic logic is_leap(input logic [YEAR_FW-1:0] year);
    return ((year % 16'd4 == 16'd0) && (year % 16'd100 != 16'd0)) || (year % 16'd400 == 16'd0);
  endfunction

  function automatic logic [DOM_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic [YEAR_FW-1:0] year);
    case (month)
      4'd2:                   return is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-per-second tick; tick_o is combinational in the last count.
// Holds its count while run_i is low; clear_i forces the count back to zero and suppresses the tick.
module rtc_prescaler #(
  parameter int CLK_HZ = 32768
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = run_i && !clear_i && (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_calendar_core.sv
// RTC/calendar: 1 Hz carry chain, validated preset load, HH:MM:SS alarm, 12/24 h presentation.
// State and pulses update one edge after the tick/load; a load always wins over a coincident tick.
module rtc_calendar_core
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 32768,
  parameter int YEAR_W   = 12,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              mode12_i,
  input  logic              load_i,
  input  logic [5:0]        load_sec_i,
  input  logic [5:0]        load_min_i,
  input  logic [4:0]        load_hour_i,
  input  logic [2:0]        load_dow_i,
  input  logic [4:0]        load_dom_i,
  input  logic [3:0]        load_month_i,
  input  logic [YEAR_W-1:0] load_year_i,
  input  logic              alarm_en_i,
  input  logic [5:0]        alarm_sec_i,
  input  logic [5:0]        alarm_min_i,
  input  logic [4:0]        alarm_hour_i,
  input  logic              alarm_clr_i,
  output logic [5:0]        sec_o,
  output logic [5:0]        min_o,
  output logic [4:0]        hour_o,
  output logic              pm_o,
  output logic [2:0]        dow_o,
  output logic [4:0]        dom_o,
  output logic [3:0]        month_o,
  output logic [YEAR_W-1:0] year_o,
  output logic              sec_tick_o,
  output logic              load_ok_o,
  output logic              load_err_o,
  output logic              year_wrap_o,
  output logic              alarm_o,
  output logic              alarm_pend_o
);

  localparam logic [YEAR_FW-1:0] YMIN = YEAR_FW'(YEAR_MIN);
  localparam logic [YEAR_FW-1:0] YMAX = YEAR_FW'(YEAR_MAX);
  localparam rtc_time_t RESET_TIME = '{year: YMIN, month: 4'd1, dom: 5'd1, dow: 3'd1,
                                       hour: 5'd0, min: 6'd0, sec: 6'd0};

  rtc_time_t time_q, time_d, tick_time, ld_time;
  logic sec_tick_q, sec_tick_d;
  logic load_ok_q, load_ok_d;
  logic load_err_q, load_err_d;
  logic year_wrap_q, year_wrap_d;
  logic alarm_q, alarm_d;
  logic alarm_pend_q, alarm_pend_d;
  logic pre_tick, ld_valid, tick_wrap, alarm_hit;
  logic [HOUR_W-1:0] hour12;

  rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run_i),
    .clear_i (load_i && ld_valid),
    .tick_o  (pre_tick)
  );

  // Candidate next time for a one-second advance, rippling through every carry.
  always_comb begin
    tick_time = time_q;
    tick_wrap = 1'b0;
    if (time_q.sec != 6'd59) begin
      tick_time.sec = time_q.sec + 6'd1;
    end else begin
      tick_time.sec = 6'd0;
      if (time_q.min != 6'd59) begin
        tick_time.min = time_q.min + 6'd1;
      end else begin
        tick_time.min = 6'd0;
        if (time_q.hour != 5'd23) begin
          tick_time.hour = time_q.hour + 5'd1;
        end else begin
          tick_time.hour = 5'd0;
          tick_time.dow  = (time_q.dow == 3'd7) ? 3'd1 : time_q.dow + 3'd1;
          if (time_q.dom < days_in_month(time_q.month, time_q.year)) begin
            tick_time.dom = time_q.dom + 5'd1;
          end else begin
            tick_time.dom = 5'd1;
            if (time_q.month != 4'd12) begin
              tick_time.month = time_q.month + 4'd1;
            end else begin
              tick_time.month = 4'd1;
              if (time_q.year >= YMAX) begin
                tick_time.year = YMIN;
                tick_wrap      = 1'b1;
              end else begin
                tick_time.year = time_q.year + 16'd1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    ld_time.sec   = load_sec_i;
    ld_time.min   = load_min_i;
    ld_time.hour  = load_hour_i;
    ld_time.dow   = load_dow_i;
    ld_time.dom   = load_dom_i;
    ld_time.month = load_month_i;
    ld_time.year  = YEAR_FW'(load_year_i);
    ld_valid = (ld_time.sec <= 6'd59) && (ld_time.min <= 6'd59) && (ld_time.hour <= 5'd23)
            && (ld_time.dow != 3'd0) && (ld_time.month != 4'd0) && (ld_time.month <= 4'd12)
            && (ld_time.year >= YMIN) && (ld_time.year <= YMAX) && (ld_time.dom != 5'd0)
            && (ld_time.dom <= days_in_month(ld_time.month, ld_time.year));
    alarm_hit = alarm_en_i && (tick_time.sec == alarm_sec_i) && (tick_time.min == alarm_min_i)
             && (tick_time.hour == alarm_hour_i);
  end

  always_comb begin
    time_d       = time_q;
    sec_tick_d   = 1'b0;
    load_ok_d    = 1'b0;
    load_err_d   = 1'b0;
    year_wrap_d  = 1'b0;
    alarm_d      = 1'b0;
    alarm_pend_d = alarm_pend_q && !alarm_clr_i;
    if (load_i) begin
      if (ld_valid) begin
        time_d    = ld_time;
        load_ok_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pre_tick) begin
      time_d      = tick_time;
      sec_tick_d  = 1'b1;
      year_wrap_d = tick_wrap;
      if (alarm_hit) begin
        alarm_d      = 1'b1;
        alarm_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      time_q       <= RESET_TIME;
      sec_tick_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      year_wrap_q  <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_pend_q <= 1'b0;
    end else begin
      time_q       <= time_d;
      sec_tick_q   <= sec_tick_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
      year_wrap_q  <= year_wrap_d;
      alarm_q      <= alarm_d;
      alarm_pend_q <= alarm_pend_d;
    end
  end

  // 12 h view is derived purely from the stored 24 h hour.
  always_comb begin
    hour12 = (time_q.hour >= 5'd12) ? time_q.hour - 5'd12 : time_q.hour;
    if (mode12_i) begin
      hour_o = (hour12 == 5'd0) ? 5'd12 : hour12;
      pm_o   = (time_q.hour >= 5'd12);
    end else begin
      hour_o = time_q.hour;
      pm_o   = 1'b0;
    end
  end

  assign sec_o        = time_q.sec;
  assign min_o        = time_q.min;
  assign dow_o        = time_q.dow;
  assign dom_o        = time_q.dom;
  assign month_o      = time_q.month;
  assign year_o       = YEAR_W'(time_q.year);
  assign sec_tick_o   = sec_tick_q;
  assign load_ok_o    = load_ok_q;
  assign load_err_o   = load_err_q;
  assign year_wrap_o  = year_wrap_q;
  assign alarm_o      = alarm_q;
  assign alarm_pend_o = alarm_pend_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench: dut runs YEAR_MAX=2099, dut_b runs YEAR_MAX=2100 on the same stimulus.
module tb_rtc_calendar_core;
  localparam int CLK_HZ = 4;
  localparam int YEAR_W = 12;

  logic clk = 1'b0;
  logic rst_i, run_i, mode12_i, load_i, alarm_en_i, alarm_clr_i;
  logic [5:0] load_sec_i, load_min_i, alarm_sec_i, alarm_min_i;
  logic [4:0] load_hour_i, load_dom_i, alarm_hour_i;
  logic [2:0] load_dow_i;
  logic [3:0] load_month_i;
  logic [YEAR_W-1:0] load_year_i;

  logic [5:0] sec_o, min_o, b_sec_o, b_min_o;
  logic [4:0] hour_o, dom_o, b_hour_o, b_dom_o;
  logic [2:0] dow_o, b_dow_o;
  logic [3:0] month_o, b_month_o;
  logic [YEAR_W-1:0] year_o, b_year_o;
  logic pm_o, sec_tick_o, load_ok_o, load_err_o, year_wrap_o, alarm_o, alarm_pend_o;
  logic b_pm_o, b_sec_tick_o, b_load_ok_o, b_load_err_o, b_year_wrap_o, b_alarm_o, b_alarm_pend_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rtc_calendar_core #(.CLK_HZ(CLK_HZ), .YEAR_W(YEAR_W), .YEAR_MIN(2000), .YEAR_MAX(2099)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .mode12_i(mode12_i), .load_i(load_i),
    .load_sec_i(load_sec_i), .load_min_i(load_min_i), .load_hour_i(load_hour_i),
    .load_dow_i(load_dow_i), .load_dom_i(load_dom_i), .load_month_i(load_month_i),
    .load_year_i(load_year_i), .alarm_en_i(alarm_en_i), .alarm_sec_i(alarm_sec_i),
    .alarm_min_i(alarm_min_i), .alarm_hour_i(alarm_hour_i), .alarm_clr_i(alarm_clr_i),
    .sec_o(sec_o), .min_o(min_o), .hour_o(hour_o), .pm_o(pm_o), .dow_o(dow_o), .dom_o(dom_o),
    .month_o(month_o), .year_o(year_o), .sec_tick_o(sec_tick_o), .load_ok_o(load_ok_o),
    .load_err_o(load_err_o), .year_wrap_o(year_wrap_o), .alarm_o(alarm_o),
    .alarm_pend_o(alarm_pend_o)
  );

  rtc_calendar_core #(.CLK_HZ(CLK_HZ), .YEAR_W(YEAR_W), .YEAR_MIN(2000), .YEAR_MAX(2100)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .mode12_i(mode12_i), .load_i(load_i),
    .load_sec_i(load_sec_i), .load_min_i(load_min_i), .load_hour_i(load_hour_i),
    .load_dow_i(load_dow_i), .load_dom_i(load_dom_i), .load_month_i(load_month_i),
    .load_year_i(load_year_i), .alarm_en_i(alarm_en_i), .alarm_sec_i(alarm_sec_i),
    .alarm_min_i(alarm_min_i), .alarm_hour_i(alarm_hour_i), .alarm_clr_i(alarm_clr_i),
    .sec_o(b_sec_o), .min_o(b_min_o), .hour_o(b_hour_o), .pm_o(b_pm_o), .dow_o(b_dow_o),
    .dom_o(b_dom_o), .month_o(b_month_o), .year_o(b_year_o), .sec_tick_o(b_sec_tick_o),
    .load_ok_o(b_load_ok_o), .load_err_o(b_load_err_o), .year_wrap_o(b_year_wrap_o),
    .alarm_o(b_alarm_o), .alarm_pend_o(b_alarm_pend_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int y, input int mo, input int d, input int dw,
                         input int h, input int mi, input int s);
    load_year_i  = YEAR_W'(y);
    load_month_i = 4'(mo);
    load_dom_i   = 5'(d);
    load_dow_i   = 3'(dw);
    load_hour_i  = 5'(h);
    load_min_i   = 6'(mi);
    load_sec_i   = 6'(s);
    load_i = 1'b1;
    cyc(1);
    load_i = 1'b0;
  endtask

  // Assumes the prescaler is at 0; leaves it at 0 with the tick pulse visible.
  task automatic do_tick();
    run_i = 1'b1;
    cyc(CLK_HZ);
    run_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; run_i = 1'b0; mode12_i = 1'b0; load_i = 1'b0;
    alarm_en_i = 1'b0; alarm_clr_i = 1'b0;
    alarm_sec_i = '0; alarm_min_i = '0; alarm_hour_i = '0;
    load_sec_i = '0; load_min_i = '0; load_hour_i = '0; load_dow_i = '0;
    load_dom_i = '0; load_month_i = '0; load_year_i = '0;

    // 1) reset values, first second, freeze
    cyc(1);
    chk("rst_sec", 32'(sec_o), 0);
    chk("rst_hour", 32'(hour_o), 0);
    chk("rst_dow", 32'(dow_o), 1);
    chk("rst_dom", 32'(dom_o), 1);
    chk("rst_month", 32'(month_o), 1);
    chk("rst_year", 32'(year_o), 2000);
    chk("rst_pend", 32'(alarm_pend_o), 0);
    rst_i = 1'b0;
    run_i = 1'b1;
    cyc(3);
    chk("pre_sec_3cyc", 32'(sec_o), 0);
    chk("pre_tick_3cyc", 32'(sec_tick_o), 0);
    cyc(1);
    chk("sec_after_4cyc", 32'(sec_o), 1);
    chk("tick_pulse", 32'(sec_tick_o), 1);
    cyc(1);
    chk("tick_one_cycle", 32'(sec_tick_o), 0);
    run_i = 1'b0;
    cyc(10);
    chk("frozen_sec", 32'(sec_o), 1);
    chk("frozen_tick", 32'(sec_tick_o), 0);

    // 2) leap day rollover, and century non-leap 2100
    do_load(2024, 2, 28, 7, 23, 59, 59);
    chk("ld_ok_2024", 32'(load_ok_o), 1);
    chk("ld_sec_2024", 32'(sec_o), 59);
    do_tick();
    chk("leap_dom", 32'(dom_o), 29);
    chk("leap_month", 32'(month_o), 2);
    chk("leap_year", 32'(year_o), 2024);
    chk("leap_hour", 32'(hour_o), 0);
    chk("leap_min", 32'(min_o), 0);
    chk("leap_sec", 32'(sec_o), 0);
    chk("leap_dow", 32'(dow_o), 1);
    do_load(2100, 2, 28, 1, 23, 59, 59);
    chk("ld_err_2100_a", 32'(load_err_o), 1);
    chk("ld_ok_2100_b", 32'(b_load_ok_o), 1);
    do_tick();
    chk("c2100_dom", 32'(b_dom_o), 1);
    chk("c2100_month", 32'(b_month_o), 3);
    chk("c2100_year", 32'(b_year_o), 2100);
    chk("a_kept_dom", 32'(dom_o), 29);
    chk("a_kept_sec", 32'(sec_o), 1);

    // 3) year-range wrap
    do_load(2099, 12, 31, 3, 23, 59, 59);
    chk("ld_ok_2099", 32'(load_ok_o), 1);
    do_tick();
    chk("wrap_year", 32'(year_o), 2000);
    chk("wrap_month", 32'(month_o), 1);
    chk("wrap_dom", 32'(dom_o), 1);
    chk("wrap_hms", 32'({hour_o, min_o, sec_o}), 0);
    chk("wrap_pulse", 32'(year_wrap_o), 1);
    chk("b_no_wrap_year", 32'(b_year_o), 2100);
    chk("b_no_wrap_pulse", 32'(b_year_wrap_o), 0);
    cyc(1);
    chk("wrap_one_cycle", 32'(year_wrap_o), 0);

    // 4) invalid preset, then load coincident with a tick
    do_load(2024, 4, 31, 2, 10, 10, 10);
    chk("apr31_err", 32'(load_err_o), 1);
    chk("apr31_no_ok", 32'(load_ok_o), 0);
    chk("apr31_month", 32'(month_o), 1);
    chk("apr31_sec", 32'(sec_o), 0);
    run_i = 1'b1;
    cyc(3);
    do_load(2030, 6, 15, 4, 10, 20, 30);
    chk("coinc_ok", 32'(load_ok_o), 1);
    chk("coinc_no_tick", 32'(sec_tick_o), 0);
    chk("coinc_hms", 32'({hour_o, min_o, sec_o}), {5'd10, 6'd20, 6'd30});
    chk("coinc_date", 32'({year_o, month_o, dom_o, dow_o}), {12'd2030, 4'd6, 5'd15, 3'd4});
    cyc(3);
    chk("presc_cleared", 32'(sec_o), 30);
    cyc(1);
    chk("after_clear_tick", 32'(sec_o), 31);
    run_i = 1'b0;

    // 5) 12 h presentation
    mode12_i = 1'b1;
    do_load(2030, 6, 15, 4, 0, 0, 0);
    chk("h0_hour12", 32'(hour_o), 12);
    chk("h0_pm", 32'(pm_o), 0);
    do_load(2030, 6, 15, 4, 12, 0, 0);
    chk("h12_hour12", 32'(hour_o), 12);
    chk("h12_pm", 32'(pm_o), 1);
    do_load(2030, 6, 15, 4, 13, 0, 0);
    chk("h13_hour12", 32'(hour_o), 1);
    chk("h13_pm", 32'(pm_o), 1);
    run_i = 1'b1;
    cyc(2);
    mode12_i = 1'b0;
    #1;
    chk("m24_hour", 32'(hour_o), 13);
    chk("m24_pm", 32'(pm_o), 0);
    cyc(1);
    mode12_i = 1'b1;
    chk("toggle_sec_held", 32'(sec_o), 0);
    cyc(1);
    chk("toggle_sec_tick", 32'(sec_o), 1);
    chk("toggle_hour12", 32'(hour_o), 1);
    run_i = 1'b0;
    mode12_i = 1'b0;

    // 6) alarm
    alarm_en_i = 1'b1; alarm_hour_i = 5'd7; alarm_min_i = 6'd30; alarm_sec_i = 6'd0;
    do_load(2030, 6, 15, 4, 7, 29, 59);
    chk("al_pre_pend", 32'(alarm_pend_o), 0);
    do_tick();
    chk("al_pulse", 32'(alarm_o), 1);
    chk("al_pend_set", 32'(alarm_pend_o), 1);
    chk("al_time", 32'({hour_o, min_o, sec_o}), {5'd7, 6'd30, 6'd0});
    cyc(1);
    chk("al_one_cycle", 32'(alarm_o), 0);
    cyc(5);
    chk("al_pend_held", 32'(alarm_pend_o), 1);
    alarm_clr_i = 1'b1;
    cyc(1);
    alarm_clr_i = 1'b0;
    chk("al_pend_clr", 32'(alarm_pend_o), 0);
    do_load(2030, 6, 15, 4, 7, 30, 0);
    chk("al_load_no_pulse", 32'(alarm_o), 0);
    chk("al_load_no_pend", 32'(alarm_pend_o), 0);
    do_load(2030, 6, 15, 4, 7, 29, 59);
    alarm_clr_i = 1'b1;
    do_tick();
    alarm_clr_i = 1'b0;
    chk("al_set_beats_clr", 32'(alarm_pend_o), 1);
    alarm_en_i = 1'b0;
    do_load(2031, 3, 3, 5, 5, 6, 7);
    run_i = 1'b1;
    cyc(2);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_hms", 32'({hour_o, min_o, sec_o}), 0);
    chk("arst_year", 32'(year_o), 2000);
    chk("arst_dow", 32'(dow_o), 1);
    chk("arst_pend", 32'(alarm_pend_o), 0);
    run_i = 1'b0;
    rst_i = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
